// File: rtl/int_pkg.sv
// int_pkg: shared constants for the two-channel countdown interrupt source.
// Holds the channel count, the default handler vectors and the channel
// indices that the arbiter and the decode-select logic use.
package int_pkg;

  localparam int unsigned NUM_CNT = 2;
  localparam int unsigned VEC_W   = 32;
  localparam int unsigned CH_W    = 1;

  localparam logic [VEC_W-1:0] DEF_VEC0 = 32'h0000_0100;
  localparam logic [VEC_W-1:0] DEF_VEC1 = 32'h0000_0180;

  // Channel indices double as the cnt_int_sel encoding.
  localparam logic [CH_W-1:0] CH0 = 1'b0;
  localparam logic [CH_W-1:0] CH1 = 1'b1;

endpackage

// File: rtl/int_counter.sv
// int_counter: one periodic countdown channel.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load_i       load value_i as reload/count and enable (value 0 disables)
//   disable_i    stop the channel and drop its pending flag, count is held
//   value_i      reload value for load_i
//   ack_i        the arbiter delivered this channel; clear pend
//   pend_o       channel has expired and not yet been delivered
//   count_o      current countdown value
module int_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             disable_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             ack_i,
  output logic             pend_o,
  output logic [WIDTH-1:0] count_o
);

  logic             en_q, en_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             expire_c;

  // Expiry is decided in the cycle the count reads 1, so the period is reload cycles.
  assign expire_c = en_q && (count_q == WIDTH'(1));

  // Next-state: a decode command overrides expiry and acknowledge in the same cycle.
  always_comb begin
    en_d     = en_q;
    pend_d   = pend_q;
    reload_d = reload_q;
    count_d  = count_q;
    if (disable_i || (load_i && (value_i == '0))) begin
      en_d   = 1'b0;
      pend_d = 1'b0;
    end else if (load_i) begin
      en_d     = 1'b1;
      pend_d   = 1'b0;
      reload_d = value_i;
      count_d  = value_i;
    end else begin
      if (en_q) begin
        count_d = expire_c ? reload_q : count_q - WIDTH'(1);
      end
      // A fresh expiry re-arms pend even if the old event is acknowledged now.
      pend_d = (pend_q & ~ack_i) | expire_c;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
      reload_q <= '0;
      count_q  <= '0;
    end else begin
      en_q     <= en_d;
      pend_q   <= pend_d;
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end

  assign pend_o  = pend_q;
  assign count_o = count_q;

endmodule

// File: rtl/int_timer.sv
// int_timer: two-channel countdown interrupt source for the pipelined core.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   cnt_int            decode holds a counter-interrupt instruction
//   cnt_int_sel        channel select
//   cnt_int_disable    1 = disable selected channel, 0 = load it
//   rti                decode holds a return-from-interrupt
//   stallD             decode stalled; decode commands ignored
//   branch_stall_D     decode holds a branch slot; delivery inhibited
//   srcaD              reload value for a load
//   pcF                fetch PC, captured as return address
//   int_en1            one-cycle interrupt request
//   int_vec            handler address of the last delivery
//   epc                saved return PC
//   in_service         a handler is running; blocks nesting
//   pending            per-channel pending flags
module int_timer
  import int_pkg::*;
#(
  parameter int unsigned       WIDTH = 32,
  parameter logic [VEC_W-1:0]  VEC0  = DEF_VEC0,
  parameter logic [VEC_W-1:0]  VEC1  = DEF_VEC1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cnt_int,
  input  logic               cnt_int_sel,
  input  logic               cnt_int_disable,
  input  logic               rti,
  input  logic               stallD,
  input  logic               branch_stall_D,
  input  logic [WIDTH-1:0]   srcaD,
  input  logic [VEC_W-1:0]   pcF,
  output logic               int_en1,
  output logic [VEC_W-1:0]   int_vec,
  output logic [VEC_W-1:0]   epc,
  output logic               in_service,
  output logic [NUM_CNT-1:0] pending
);

  logic               cmd_c;
  logic               deliver_c;
  logic [NUM_CNT-1:0] sel_c, load_c, dis_c, ack_c, pend_c;

  // Channel counts are brought out for observation only.
  logic [WIDTH-1:0]   ch0_count_unused;
  logic [WIDTH-1:0]   ch1_count_unused;

  logic               int_en1_q, int_en1_d;
  logic [VEC_W-1:0]   int_vec_q, int_vec_d;
  logic [VEC_W-1:0]   epc_q, epc_d;
  logic               in_service_q, in_service_d;

  // Decode command steering to the selected channel.
  assign cmd_c      = cnt_int & ~stallD;
  assign sel_c[CH0] = cmd_c & (cnt_int_sel == CH0);
  assign sel_c[CH1] = cmd_c & (cnt_int_sel == CH1);
  assign load_c     = sel_c & {NUM_CNT{~cnt_int_disable}};
  assign dis_c      = sel_c & {NUM_CNT{cnt_int_disable}};

  // Delivery gating; any decode-side instruction of ours also blocks delivery.
  assign deliver_c = ~in_service_q & (|pend_c) & ~stallD & ~branch_stall_D
                     & ~rti & ~cnt_int;

  // Fixed priority: channel 0 wins, channel 1 keeps its flag.
  assign ack_c[CH0] = deliver_c & pend_c[CH0];
  assign ack_c[CH1] = deliver_c & ~pend_c[CH0] & pend_c[CH1];

  int_counter #(.WIDTH(WIDTH)) u_ch0 (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load_c[CH0]),
    .disable_i (dis_c[CH0]),
    .value_i   (srcaD),
    .ack_i     (ack_c[CH0]),
    .pend_o    (pend_c[CH0]),
    .count_o   (ch0_count_unused)
  );

  int_counter #(.WIDTH(WIDTH)) u_ch1 (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load_c[CH1]),
    .disable_i (dis_c[CH1]),
    .value_i   (srcaD),
    .ack_i     (ack_c[CH1]),
    .pend_o    (pend_c[CH1]),
    .count_o   (ch1_count_unused)
  );

  // Request, vector, return address and service flag next-state.
  always_comb begin
    int_en1_d    = deliver_c;
    int_vec_d    = int_vec_q;
    epc_d        = epc_q;
    in_service_d = in_service_q;
    if (deliver_c) begin
      int_vec_d    = ack_c[CH0] ? VEC0 : VEC1;
      epc_d        = pcF;
      in_service_d = 1'b1;
    end else if (rti && !stallD && in_service_q) begin
      in_service_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_en1_q    <= 1'b0;
      int_vec_q    <= '0;
      epc_q        <= '0;
      in_service_q <= 1'b0;
    end else begin
      int_en1_q    <= int_en1_d;
      int_vec_q    <= int_vec_d;
      epc_q        <= epc_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_en1    = int_en1_q;
  assign int_vec    = int_vec_q;
  assign epc        = epc_q;
  assign in_service = in_service_q;
  assign pending    = pend_c;

endmodule

// File: tb/tb_int_timer.sv
// tb_int_timer: directed stimulus for int_timer with an event-level model
// (channels tracked by their next expiry edge) and literal spot checks.
module tb_int_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cnt_int, cnt_int_sel, cnt_int_disable, rti, stallD, branch_stall_D;
  logic [31:0] srcaD, pcF;
  logic        int_en1;
  logic [31:0] int_vec, epc;
  logic        in_service;
  logic [1:0]  pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  int_timer dut (
    .clk             (clk),
    .reset           (reset),
    .cnt_int         (cnt_int),
    .cnt_int_sel     (cnt_int_sel),
    .cnt_int_disable (cnt_int_disable),
    .rti             (rti),
    .stallD          (stallD),
    .branch_stall_D  (branch_stall_D),
    .srcaD           (srcaD),
    .pcF             (pcF),
    .int_en1         (int_en1),
    .int_vec         (int_vec),
    .epc             (epc),
    .in_service      (in_service),
    .pending         (pending)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an enabled channel expires at edge m_next, then every m_period edges.
  int          e = 0;
  bit          m_en[2];
  int          m_next[2];
  int          m_period[2];
  int          m_held[2];
  bit          m_pend[2];
  bit          m_insvc = 1'b0;
  bit          m_int   = 1'b0;
  logic [31:0] m_vec   = '0;
  logic [31:0] m_epc   = '0;

  function automatic int m_count(input int ch);
    return m_en[ch] ? (m_next[ch] - e) : m_held[ch];
  endfunction

  initial begin
    for (int c = 0; c < 2; c++) begin
      m_en[c] = 0; m_next[c] = 0; m_period[c] = 0; m_held[c] = 0; m_pend[c] = 0;
    end
  end

  initial forever begin : model
    bit deliver;
    int win;
    bit hit;
    bit expd;
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_en[c] = 0; m_next[c] = 0; m_period[c] = 0; m_held[c] = 0; m_pend[c] = 0;
      end
      m_insvc = 0; m_int = 0; m_vec = '0; m_epc = '0;
    end else begin
      e++;
      deliver = !m_insvc && (m_pend[0] || m_pend[1]) && !stallD && !branch_stall_D
                && !rti && !cnt_int;
      win = m_pend[0] ? 0 : 1;
      m_int = deliver;
      if (deliver) begin
        m_vec   = (win == 0) ? 32'h0000_0100 : 32'h0000_0180;
        m_epc   = pcF;
        m_insvc = 1;
      end else if (rti && !stallD && m_insvc) begin
        m_insvc = 0;
      end
      for (int c = 0; c < 2; c++) begin
        hit = cnt_int && !stallD && (int'(cnt_int_sel) == c);
        if (hit && (cnt_int_disable || srcaD == 0)) begin
          if (m_en[c]) m_held[c] = m_next[c] - e + 1;
          m_en[c]   = 0;
          m_pend[c] = 0;
        end else if (hit) begin
          m_en[c]     = 1;
          m_period[c] = int'(srcaD);
          m_next[c]   = e + int'(srcaD);
          m_pend[c]   = 0;
        end else begin
          expd = m_en[c] && (e == m_next[c]);
          if (deliver && win == c) m_pend[c] = 0;
          if (expd) begin
            m_pend[c] = 1;
            m_next[c] = m_next[c] + m_period[c];
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin : compare
    @(negedge clk);
    if (!reset) begin
      check("cyc_int_en1", int_en1, m_int);
      check("cyc_int_vec", int_vec, m_vec);
      check("cyc_epc", epc, m_epc);
      check("cyc_in_service", in_service, m_insvc);
      check("cyc_pending", pending, {m_pend[1], m_pend[0]});
      check("cyc_count0", dut.ch0_count_unused, 32'(m_count(0)));
      check("cyc_count1", dut.ch1_count_unused, 32'(m_count(1)));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      pcF = pcF + 32'h4;
    end
  endtask

  task automatic cmd(input logic sel, input logic dis, input logic [31:0] val);
    cnt_int = 1'b1; cnt_int_sel = sel; cnt_int_disable = dis; srcaD = val;
    cyc(1);
    cnt_int = 1'b0; cnt_int_disable = 1'b0; srcaD = '0;
  endtask

  logic [31:0] pc_exp;

  initial begin
    reset = 1'b1;
    cnt_int = 0; cnt_int_sel = 0; cnt_int_disable = 0; rti = 0;
    stallD = 0; branch_stall_D = 0; srcaD = '0; pcF = 32'h0040_0000;
    cyc(2);
    check("rst_int_en1", int_en1, 0);
    check("rst_int_vec", int_vec, 0);
    check("rst_epc", epc, 0);
    check("rst_in_service", in_service, 0);
    check("rst_pending", pending, 0);
    reset = 1'b0;
    cyc(1);

    // Single channel: load ch0 with 5.
    cmd(1'b0, 1'b0, 32'd5);
    check("t1_count_load", dut.ch0_count_unused, 32'd5);
    cyc(4);
    check("t1_pend_early", pending, 2'b00);
    cyc(1);
    check("t1_pend_rise", pending, 2'b01);
    pc_exp = pcF;
    cyc(1);
    check("t1_int_en1", int_en1, 1);
    check("t1_int_vec", int_vec, 32'h100);
    check("t1_epc", epc, pc_exp);
    check("t1_in_service", in_service, 1);
    check("t1_pend_ack", pending, 2'b00);
    cyc(1);
    check("t1_pulse_one", int_en1, 0);
    rti = 1'b1; cyc(1); rti = 1'b0;
    check("t1_rti", in_service, 0);
    cmd(1'b0, 1'b1, 32'd0);
    check("t1_count_held", dut.ch0_count_unused, 32'd2);

    // Two channels and priority.
    cmd(1'b0, 1'b0, 32'd3);
    cmd(1'b1, 1'b0, 32'd3);
    cyc(2);
    check("t2_pend0", pending, 2'b01);
    cyc(1);
    check("t2_int_en1", int_en1, 1);
    check("t2_vec0", int_vec, 32'h100);
    check("t2_pend1_kept", pending, 2'b10);
    cmd(1'b0, 1'b1, 32'd0);
    check("t2_no_nest", int_en1, 0);
    cyc(1);
    check("t2_still_pend", pending, 2'b10);
    rti = 1'b1; cyc(1); rti = 1'b0;
    check("t2_rti_clear", in_service, 0);
    check("t2_rti_no_int", int_en1, 0);
    cyc(1);
    check("t2_int_en1_ch1", int_en1, 1);
    check("t2_vec1", int_vec, 32'h180);
    check("t2_pend_clear", pending, 2'b00);
    cmd(1'b1, 1'b1, 32'd0);
    rti = 1'b1; cyc(1); rti = 1'b0;

    // Gating by stallD then branch_stall_D; then disable racing an expiry.
    cmd(1'b0, 1'b0, 32'd3);
    stallD = 1'b1;
    cyc(3);
    check("t3_pend", pending, 2'b01);
    cyc(2);
    check("t3_stall_block", int_en1, 0);
    stallD = 1'b0; branch_stall_D = 1'b1;
    cyc(2);
    check("t3_branch_block", int_en1, 0);
    check("t3_coalesce", pending, 2'b01);
    branch_stall_D = 1'b0;
    cyc(1);
    check("t3_release_int", int_en1, 1);
    check("t3_release_vec", int_vec, 32'h100);
    cmd(1'b0, 1'b1, 32'd0);
    check("t3_dis_wins", pending, 2'b00);
    check("t3_dis_count", dut.ch0_count_unused, 32'd1);
    cyc(3);
    check("t3_stopped", dut.ch0_count_unused, 32'd1);
    rti = 1'b1; cyc(1); rti = 1'b0;

    // Load of zero disables.
    cmd(1'b1, 1'b0, 32'd5);
    cmd(1'b1, 1'b0, 32'd0);
    check("t4_zero_held", dut.ch1_count_unused, 32'd5);
    cyc(6);
    check("t4_zero_pend", pending, 2'b00);
    check("t4_zero_stopped", dut.ch1_count_unused, 32'd5);

    // Periodic channel 1, never returned from.
    cmd(1'b1, 1'b0, 32'd4);
    cyc(4);
    check("t5_pend", pending, 2'b10);
    cyc(1);
    check("t5_int_en1", int_en1, 1);
    check("t5_vec", int_vec, 32'h180);
    cyc(2);
    check("t5_count_one", dut.ch1_count_unused, 32'd1);
    cyc(1);
    check("t5_wrap", dut.ch1_count_unused, 32'd4);
    check("t5_pend_again", pending, 2'b10);
    cyc(4);
    check("t5_coalesce", pending, 2'b10);
    check("t5_wrap2", dut.ch1_count_unused, 32'd4);
    check("t5_no_nest", int_en1, 0);

    // Reset in the middle of counting and service.
    cmd(1'b0, 1'b0, 32'd7);
    cyc(2);
    #2 reset = 1'b1;
    #1;
    check("t6_int_en1", int_en1, 0);
    check("t6_int_vec", int_vec, 0);
    check("t6_epc", epc, 0);
    check("t6_in_service", in_service, 0);
    check("t6_pending", pending, 0);
    check("t6_count0", dut.ch0_count_unused, 0);
    check("t6_count1", dut.ch1_count_unused, 0);
    cyc(1);
    reset = 1'b0;
    cyc(20);
    check("t6_quiet_int", int_en1, 0);
    check("t6_quiet_pend", pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
